instruction_memory: RTL and testbench

Word-addressed instruction store for the single-cycle CPU datapath. It sits between the program counter and the instruction decoder. It returns the 32-bit instruction at a byte address combinationally. A synchronous loader port fills the store, and synchronous reset fills the whole array with NOPs.

---
 rtl/instruction_memory.sv | 42 ++++
 tb/tb_instruction_memory.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// instruction_memory: combinational-read, synchronously loaded instruction store with NOP reset fill.
// Optional IMEM_BOUNDS_CHECK_EN flags misaligned/out-of-range fetches and drops such loader writes.
module instruction_memory #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic        fault
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] ridx, widx;
  logic          wen;
  assign ridx = address[AW+1:2];
  assign widx = waddr[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
  assign fault       = (address[1:0] != 2'b00) || (address >= LIMIT);
  assign wen         = we && (waddr[1:0] == 2'b00) && (waddr < LIMIT);
  assign instruction = fault ? NOP_WORD : mem_q[ridx];
`else
  logic unused_bits;
  assign unused_bits = ^{address[31:AW+2], address[1:0], waddr[31:AW+2], waddr[1:0], LIMIT};
  assign fault       = 1'b0;
  assign wen         = we;
  assign instruction = mem_q[ridx];
`endif
  // Reset fills every word and takes priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_WORD;
    end else if (wen) begin
      mem_q[widx] <= wdata;
    end
  end
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed and random checks of instruction_memory against an array model.
module tb_instruction_memory;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] instruction;
  logic        we = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        fault;
  logic [31:0] ref_mem [DEPTH];
  int n_chk = 0;
  int n_fail = 0;

  instruction_memory #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .address(address), .instruction(instruction),
    .we(we), .waddr(waddr), .wdata(wdata), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit addr_bad(input logic [31:0] a);
    return BOUNDS && ((a % 4) != 0 || a >= 4 * DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step(input bit r, input bit w, input logic [31:0] wa, input logic [31:0] wd);
    reset = r; we = w; waddr = wa; wdata = wd;
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    if (r) for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    else if (w && !addr_bad(wa)) ref_mem[(wa / 4) % DEPTH] = wd;
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bit          f;
    logic [31:0] e;
    address = a;
    #1;
    f = addr_bad(a);
    e = f ? NOP : ref_mem[(a / 4) % DEPTH];
    chk({tag, ".instr"}, instruction, e);
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, f});
  endtask

  initial begin
    logic [31:0] wa, ra;
    int          r;
    edge_step(1'b1, 1'b0, '0, '0);
    for (int a = 0; a <= 96; a += 4) begin
      rd("reset_sweep", 32'(a));
      chk("reset_nop", instruction, NOP);
      #8;
    end
    edge_step(1'b0, 1'b1, 32'd0, 32'h0050_0093);
    edge_step(1'b0, 1'b1, 32'd4, 32'h00A0_0113);
    edge_step(1'b0, 1'b1, 32'd8, 32'h0020_81B3);
    rd("load0", 32'd0);  chk("load0_const", instruction, 32'h0050_0093);
    rd("load4", 32'd4);  chk("load4_const", instruction, 32'h00A0_0113);
    rd("load8", 32'd8);  chk("load8_const", instruction, 32'h0020_81B3);
    rd("load12", 32'd12); chk("load12_const", instruction, NOP);
    edge_step(1'b0, 1'b1, 32'd4, 32'h1111_1111);
    edge_step(1'b0, 1'b1, 32'd4, 32'h2222_2222);
    rd("b2b_same", 32'd4); chk("b2b_const", instruction, 32'h2222_2222);
    edge_step(1'b1, 1'b1, 32'd16, 32'hDEAD_BEEF);
    rd("rst_prio16", 32'd16); chk("rst_prio_const", instruction, NOP);
    rd("rst_discard0", 32'd0); chk("rst_discard_const", instruction, NOP);
    address = 32'd20;
    we = 1'b1; waddr = 32'd20; wdata = 32'h1234_5678;
    #1;
    chk("pre_edge", instruction, NOP);
    edge_step(1'b0, 1'b1, 32'd20, 32'h1234_5678);
    chk("post_edge", instruction, 32'h1234_5678);
`ifdef IMEM_BOUNDS_CHECK_EN
    rd("oor256", 32'd256); chk("oor256_nop", instruction, NOP); chk("oor256_fault", {31'b0, fault}, 32'd1);
    rd("mis6", 32'd6);     chk("mis6_nop", instruction, NOP);   chk("mis6_fault", {31'b0, fault}, 32'd1);
    edge_step(1'b0, 1'b1, 32'd0, 32'hCAFE_F00D);
    edge_step(1'b0, 1'b1, 32'd256, 32'hBAD0_0BAD);
    edge_step(1'b0, 1'b1, 32'd2, 32'hBAD0_0BAD);
    rd("wr_oor0", 32'd0); chk("wr_oor0_const", instruction, 32'hCAFE_F00D);
`else
    edge_step(1'b0, 1'b1, 32'd0, 32'hCAFE_F00D);
    rd("wrap256", 32'd256); chk("wrap256_const", instruction, 32'hCAFE_F00D);
    rd("low2", 32'd2);      chk("low2_const", instruction, 32'hCAFE_F00D);
    chk("fault_zero", {31'b0, fault}, 32'd0);
    edge_step(1'b0, 1'b1, 32'd262, 32'h0BAD_F00D);
    rd("wr_wrap", 32'd4); chk("wr_wrap_const", instruction, 32'h0BAD_F00D);
`endif
    for (int k = 0; k < 300; k++) begin
      r  = int'($urandom_range(0, 39));
      wa = {$urandom_range(0, DEPTH + 7), 2'b00};
      if ($urandom_range(0, 7) == 0) wa = wa | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) wa = $urandom;
      if (r == 0) edge_step(1'b1, 1'($urandom_range(0, 1)), wa, $urandom);
      else if (r < 28) edge_step(1'b0, 1'b1, wa, $urandom);
      else edge_step(1'b0, 1'b0, wa, $urandom);
      ra = {$urandom_range(0, DEPTH + 7), 2'b00};
      if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      rd("rand", ra);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
